// File: rtl/gpio_io_conditioner.sv
// gpio_io_conditioner: core reset synchroniser, debounced GPIO inputs with edge pulses, gated GPIO outputs
module gpio_io_conditioner #(
    parameter int GPIO_W      = 34,
    parameter int NUM_IN      = 15,
    parameter int IN_BASE     = 0,
    parameter int NUM_OUT     = 3,
    parameter int OUT_BASE    = 15,
    parameter int RST_STAGES  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic               clk,
    input  logic               gated_reset,
    input  logic [GPIO_W-1:0]  gpio_in,
    output logic [GPIO_W-1:0]  gpio_out,
    output logic [GPIO_W-1:0]  gpio_oeb,
    output logic               core_nrst,
    output logic [NUM_IN-1:0]  core_in,
    output logic [NUM_IN-1:0]  core_rise,
    output logic [NUM_IN-1:0]  core_fall,
    input  logic [NUM_OUT-1:0] core_out,
    input  logic [NUM_OUT-1:0] core_oe
);
    localparam int CW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    if (IN_BASE < 0 || OUT_BASE < 0 || IN_BASE + NUM_IN > GPIO_W || OUT_BASE + NUM_OUT > GPIO_W) begin : g_range_err
        $error("gpio_io_conditioner: pin range outside GPIO bus");
    end
    if (!(IN_BASE + NUM_IN <= OUT_BASE || OUT_BASE + NUM_OUT <= IN_BASE)) begin : g_overlap_err
        $error("gpio_io_conditioner: input and output ranges overlap");
    end
    if (RST_STAGES < 2 || SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_stage_err
        $error("gpio_io_conditioner: stage or debounce count too small");
    end

    logic [RST_STAGES-1:0]                rst_q;
    logic [SYNC_STAGES-1:0][NUM_IN-1:0]   sync_q;
    logic [NUM_IN-1:0]                    s;
    logic                                 unused_pins;

    assign unused_pins = ^gpio_in;
    assign core_nrst   = rst_q[RST_STAGES-1];
    assign s           = sync_q[SYNC_STAGES-1];

    // Core reset: asserts immediately, releases after RST_STAGES clean edges
    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) rst_q <= '0;
        else rst_q <= {rst_q[RST_STAGES-2:0], 1'b1};
    end

    // Metastability synchroniser shared by all input channels
    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) sync_q <= '0;
        else sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in[IN_BASE +: NUM_IN]};
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          d;
        logic          rise;
        logic          fall;

        assign core_in[i]   = d;
        assign core_rise[i] = rise;
        assign core_fall[i] = fall;

        // Accept a new level only after DB_CYCLES consecutive differing samples
        always_ff @(posedge clk or negedge gated_reset) begin
            if (!gated_reset) begin
                cnt  <= '0;
                d    <= 1'b0;
                rise <= 1'b0;
                fall <= 1'b0;
            end else begin
                rise <= 1'b0;
                fall <= 1'b0;
                if (s[i] == d) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    cnt  <= '0;
                    d    <= s[i];
                    rise <= s[i];
                    fall <= ~s[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Drive only the output range; everything else stays tristated with value 0
    always_comb begin
        gpio_out = '0;
        gpio_oeb = '1;
        gpio_out[OUT_BASE +: NUM_OUT] = core_out;
        gpio_oeb[OUT_BASE +: NUM_OUT] = ~(core_oe & {NUM_OUT{core_nrst}});
    end
endmodule
